lc3_control_fsm: RTL and testbench
==================================

Name: lc3_control_fsm

Overview:
- Upstream control unit for the LC-3 datapath.
- Each cycle, from IR, BEN, Run and Continue, it produces every datapath load, gate and mux-select signal, plus the active-low SRAM strobes.
- It implements fetch, decode and the execute sequences for ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE, with memory accesses stretched over a parameterised number of cycles.

Parameters:
MEM_WAIT_CYCLES, 2, cycles each memory read/write state is held (>=1); MDR load or write completes on the last cycle
PAUSE_ON_FETCH, 0, when 1 the FSM stops after every IR load and waits for a Continue press/release

Ports:
Clk  in  1  system clock, rising edge
Reset_ah  in  1  asynchronous active-high reset
Run  in  1  start execution from HALTED
Continue  in  1  resume from pause states
IR  in  16  instruction register from datapath
BEN  in  1  branch enable from datapath
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads
GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers (at most one asserted)
PCMUX  out  2  00 BUS, 01 ADDER, 10 PC+1
ADDR2MUX  out  2  00 SEXT11, 01 SEXT9, 10 SEXT6, 11 zero
ADDR1MUX  out  1  0 SR1, 1 PC
SR1MUX  out  1  0 IR[11:9], 1 IR[8:6]
DRMUX  out  1  0 IR[11:9], 1 R7
ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS-A
MIO_EN  out  1  1 routes memory data into MDR
Mem_CE_n, Mem_OE_n, Mem_WE_n  out  1 each  SRAM strobes, active low

Behaviour:
Outputs and reset:
- Moore outputs decoded from the current state only.
- Every signal not listed for a state is 0; strobes are 1.
- Reset_ah asserted at any time, including mid-memory-access:
  - state goes to HALTED and the wait counter clears.
  - all outputs deassert immediately (strobes go high), with no clock required.

States (one clock each unless noted):
- HALTED: idle. Run=1 -> S18.
- S18: GatePC, LD_MAR, PCMUX=10, LD_PC -> S33.
- S33 (read): Mem_CE_n=0, Mem_OE_n=0, MIO_EN=1.
  - Held MEM_WAIT_CYCLES cycles using the counter.
  - LD_MDR=1 only on the final cycle, then -> S35.
- S35: GateMDR, LD_IR.
  - PAUSE_ON_FETCH=1 -> PAUSE_IR1; otherwise -> S32.
- PAUSE_IR1: waits for Continue=1 -> PAUSE_IR2.
- PAUSE_IR2: waits for Continue=0 -> S32.
- S32: LD_BEN. Dispatches on IR[15:12]:
  - 0001 -> S1; 0101 -> S5; 1001 -> S9; 0000 -> S0; 1100 -> S12; 0100 -> S4; 0110 -> S6; 0111 -> S7; 1101 -> S13.
  - Any other opcode -> S18 (treated as NOP).
- S1 ADD / S5 AND / S9 NOT:
  - SR1MUX=1, DRMUX=0, GateALU, LD_REG, LD_CC.
  - ALUK = 00 / 01 / 10 respectively.
  - -> S18.
- S0: BEN=1 -> S22; otherwise -> S18. BEN used is the value registered in S32.
- S22: ADDR1MUX=1, ADDR2MUX=01, PCMUX=01, LD_PC -> S18.
- S12 JMP: SR1MUX=1, ADDR1MUX=0, ADDR2MUX=11, PCMUX=01, LD_PC -> S18.
- S4: GatePC, DRMUX=1, LD_REG -> S21. (R7 <- PC)
- S21: ADDR1MUX=1, ADDR2MUX=00, PCMUX=01, LD_PC -> S18.
- S6: SR1MUX=1, ADDR1MUX=0, ADDR2MUX=10, GateMARMUX, LD_MAR -> S25.
- S25: identical to S33 (counted read, LD_MDR on last cycle) -> S27.
- S27: GateMDR, DRMUX=0, LD_REG, LD_CC -> S18.
- S7: same as S6 -> S23.
- S23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR -> S16.
- S16 (write): Mem_CE_n=0, Mem_WE_n=0, held MEM_WAIT_CYCLES cycles -> S18.
- S13 PAUSE: LD_LED on the first cycle.
  - Waits for Continue=1 -> S13b.
  - S13b waits for Continue=0 -> S18.

Boundary rules:
- Wait counter reloads on entry to every memory state.
- MEM_WAIT_CYCLES=1 gives single-cycle memory states.
- Run is ignored outside HALTED.
- Continue is ignored outside the pause states.
- A Continue already high on entry to a pause state does not skip the release wait.

Decomposition:
- Shared package lc3_pkg holds:
  - state enum;
  - opcode constants;
  - PCMUX, ADDR2MUX and ALUK encoding constants.
- Sub-module mem_wait_counter: load on entry, assert done on the last cycle; reusable by S33, S25 and S16.

Test Plan:
- Reset mid-S33 with Mem_OE_n=0 -> Mem_OE_n=1 before the next edge; state HALTED; all loads 0.
- Run=1, IR=16'h1283 (ADD R1,R2,R3), MEM_WAIT_CYCLES=2:
  - S18 one cycle, S33 two cycles with LD_MDR only on the second, then S35, S32, S1.
  - S1 asserts LD_REG, LD_CC, GateALU with ALUK=00.
  - Total 6 cycles Run-to-S18.
- IR=16'h0A05 (BRnp) in two runs:
  - BEN=1 in S32 -> S0, S22 with PCMUX=01, ADDR2MUX=01, ADDR1MUX=1.
  - BEN=0 -> S0 then directly S18.
- IR=16'h4800 (JSR): S4 asserts DRMUX=1, GatePC, LD_REG; S21 asserts PCMUX=01, ADDR2MUX=00.
- IR=16'h7285 (STR): sequence S7, S23, S16. S16 holds Mem_WE_n=0 exactly MEM_WAIT_CYCLES cycles and never asserts Mem_OE_n.
- IR=16'hD0FF (PAUSE), with Continue held high before entry:
  - FSM stays in S13 until Continue goes 0 then 1, then waits in S13b for release.
  - LD_LED pulses once.

Source files
------------

// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared state, opcode and mux-encoding definitions for the LC-3 control unit
package lc3_pkg;

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, PAUSE_IR1, PAUSE_IR2, S32,
        S1, S5, S9, S0, S22, S12, S4, S21,
        S6, S25, S27, S7, S23, S16, S13, S13B
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_BUS   = 2'b00;
    localparam logic [1:0] PCMUX_ADDER = 2'b01;
    localparam logic [1:0] PCMUX_INC   = 2'b10;

    localparam logic [1:0] ADDR2_SEXT11 = 2'b00;
    localparam logic [1:0] ADDR2_SEXT9  = 2'b01;
    localparam logic [1:0] ADDR2_SEXT6  = 2'b10;
    localparam logic [1:0] ADDR2_ZERO   = 2'b11;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    function automatic logic is_mem_state(input state_t s);
        return (s == S33) || (s == S25) || (s == S16);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - stretches a memory state over WAIT_CYCLES clocks, done on the last one
module mem_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LAST;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lc3_control_fsm.sv
// rtl/lc3_control_fsm.sv - LC-3 fetch/decode/execute control FSM with Moore datapath controls
module lc3_control_fsm
    import lc3_pkg::*;
#(
    parameter int unsigned MEM_WAIT_CYCLES = 2,
    parameter bit          PAUSE_ON_FETCH  = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset_ah,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        LD_LED,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic [1:0]  ADDR2MUX,
    output logic        ADDR1MUX,
    output logic        SR1MUX,
    output logic        DRMUX,
    output logic [1:0]  ALUK,
    output logic        MIO_EN,
    output logic        Mem_CE_n,
    output logic        Mem_OE_n,
    output logic        Mem_WE_n
);

    state_t     state, state_next;
    logic       mem_done, mem_load;
    logic       entered;
    logic       armed;
    logic [3:0] opcode;
    logic       unused_ir;

    assign opcode    = IR[15:12];
    assign unused_ir = ^IR[11:0];
    assign mem_load  = is_mem_state(state_next) && (state_next != state);

    mem_wait_counter #(.WAIT_CYCLES(MEM_WAIT_CYCLES)) u_wait (
        .clk  (Clk),
        .rst  (Reset_ah),
        .load (mem_load),
        .done (mem_done)
    );

    // armed: Continue has been seen low since entering the current state, so a
    // press already held on entry cannot satisfy a wait-for-press.
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            state   <= HALTED;
            entered <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state   <= state_next;
            entered <= (state_next != state);
            armed   <= (state_next == state) && (armed || !Continue);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HALTED:    if (Run) state_next = S18;
            S18:       state_next = S33;
            S33:       if (mem_done) state_next = S35;
            S35:       state_next = PAUSE_ON_FETCH ? PAUSE_IR1 : S32;
            PAUSE_IR1: if (armed && Continue) state_next = PAUSE_IR2;
            PAUSE_IR2: if (!Continue) state_next = S32;
            S32: begin
                case (opcode)
                    OP_ADD:   state_next = S1;
                    OP_AND:   state_next = S5;
                    OP_NOT:   state_next = S9;
                    OP_BR:    state_next = S0;
                    OP_JMP:   state_next = S12;
                    OP_JSR:   state_next = S4;
                    OP_LDR:   state_next = S6;
                    OP_STR:   state_next = S7;
                    OP_PAUSE: state_next = S13;
                    default:  state_next = S18;
                endcase
            end
            S1, S5, S9: state_next = S18;
            S0:        state_next = BEN ? S22 : S18;
            S22, S12:  state_next = S18;
            S4:        state_next = S21;
            S21:       state_next = S18;
            S6:        state_next = S25;
            S25:       if (mem_done) state_next = S27;
            S27:       state_next = S18;
            S7:        state_next = S23;
            S23:       state_next = S16;
            S16:       if (mem_done) state_next = S18;
            S13:       if (armed && Continue) state_next = S13B;
            S13B:      if (!Continue) state_next = S18;
            default:   state_next = HALTED;
        endcase
    end

    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_BUS;
        ADDR2MUX   = ADDR2_SEXT11;
        ADDR1MUX   = 1'b0;
        SR1MUX     = 1'b0;
        DRMUX      = 1'b0;
        ALUK       = ALUK_ADD;
        MIO_EN     = 1'b0;
        Mem_CE_n   = 1'b1;
        Mem_OE_n   = 1'b1;
        Mem_WE_n   = 1'b1;
        case (state)
            S18: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                PCMUX  = PCMUX_INC;
                LD_PC  = 1'b1;
            end
            S33, S25: begin
                Mem_CE_n = 1'b0;
                Mem_OE_n = 1'b0;
                MIO_EN   = 1'b1;
                LD_MDR   = mem_done;
            end
            S35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S32: LD_BEN = 1'b1;
            S1, S5, S9: begin
                SR1MUX  = 1'b1;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                ALUK    = (state == S1) ? ALUK_ADD : (state == S5) ? ALUK_AND : ALUK_NOT;
            end
            S22, S21: begin
                ADDR1MUX = 1'b1;
                ADDR2MUX = (state == S22) ? ADDR2_SEXT9 : ADDR2_SEXT11;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            S12: begin
                SR1MUX   = 1'b1;
                ADDR2MUX = ADDR2_ZERO;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            S4: begin
                GatePC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
            end
            S6, S7: begin
                SR1MUX     = 1'b1;
                ADDR2MUX   = ADDR2_SEXT6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            S27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S23: begin
                ALUK    = ALUK_PASS;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            S16: begin
                Mem_CE_n = 1'b0;
                Mem_WE_n = 1'b0;
            end
            S13: LD_LED = entered;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb/tb_lc3_control_fsm.sv - directed-vector bench for lc3_control_fsm
module tb_lc3_control_fsm;

    logic        Clk = 1'b0;
    logic        Reset_ah, Run, Continue, BEN;
    logic [15:0] IR;
    logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic ADDR1MUX, SR1MUX, DRMUX, MIO_EN, Mem_CE_n, Mem_OE_n, Mem_WE_n;

    int n_cmp = 0;
    int n_bad = 0;
    int led_count = 0;

    lc3_control_fsm #(.MEM_WAIT_CYCLES(2), .PAUSE_ON_FETCH(1'b0)) dut (
        .Clk(Clk), .Reset_ah(Reset_ah), .Run(Run), .Continue(Continue), .IR(IR), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
        .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX),
        .DRMUX(DRMUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
        .Mem_CE_n(Mem_CE_n), .Mem_OE_n(Mem_OE_n), .Mem_WE_n(Mem_WE_n)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (LD_LED) led_count++;

    logic [24:0] ctl;
    assign ctl = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX,
                  PCMUX, ADDR2MUX, ADDR1MUX, SR1MUX, DRMUX, ALUK, MIO_EN,
                  Mem_CE_n, Mem_OE_n, Mem_WE_n};

    function automatic logic [24:0] cw(input logic [7:0] ld, input logic [3:0] gt,
                                       input logic [1:0] pcm, input logic [1:0] a2,
                                       input logic a1, input logic sr1, input logic dr,
                                       input logic [1:0] aluk, input logic mio,
                                       input logic [2:0] strb);
        return {ld, gt, pcm, a2, a1, sr1, dr, aluk, mio, strb};
    endfunction

    logic [24:0] W_IDLE, W_S18, W_S33, W_S33L, W_S35, W_S32, W_S1, W_S5, W_S22, W_S12;
    logic [24:0] W_S4, W_S21, W_S6, W_S27, W_S23, W_S16, W_S13L;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [24:0] w);
        @(negedge Clk);
        check_eq(tag, 32'(ctl), 32'(w));
    endtask

    task automatic do_reset();
        Reset_ah = 1'b1;
        Run = 1'b0;
        #1;
        check_eq("rst_async", 32'(ctl), 32'(W_IDLE));
        @(negedge Clk);
        Reset_ah = 1'b0;
        @(negedge Clk);
        check_eq("rst_halted", 32'(ctl), 32'(W_IDLE));
    endtask

    task automatic fetch(input string tag, input logic [15:0] ir, input logic ben);
        IR = ir;
        BEN = ben;
        Run = 1'b1;
        cyc({tag, "_s18"}, W_S18);
        Run = 1'b0;
        cyc({tag, "_s33a"}, W_S33);
        cyc({tag, "_s33b"}, W_S33L);
        cyc({tag, "_s35"}, W_S35);
        cyc({tag, "_s32"}, W_S32);
    endtask

    initial begin
        int led_base;
        W_IDLE = cw(8'h00, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 3'b111);
        W_S18  = cw(8'b1000_0010, 4'b1000, 2'b10, 2'b00, 0, 0, 0, 2'b00, 0, 3'b111);
        W_S33  = cw(8'h00, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 2'b00, 1, 3'b001);
        W_S33L = cw(8'b0100_0000, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 2'b00, 1, 3'b001);
        W_S35  = cw(8'b0010_0000, 4'b0100, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 3'b111);
        W_S32  = cw(8'b0001_0000, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 3'b111);
        W_S1   = cw(8'b0000_1100, 4'b0010, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 3'b111);
        W_S5   = cw(8'b0000_1100, 4'b0010, 2'b00, 2'b00, 0, 1, 0, 2'b01, 0, 3'b111);
        W_S22  = cw(8'b0000_0010, 4'b0000, 2'b01, 2'b01, 1, 0, 0, 2'b00, 0, 3'b111);
        W_S12  = cw(8'b0000_0010, 4'b0000, 2'b01, 2'b11, 0, 1, 0, 2'b00, 0, 3'b111);
        W_S4   = cw(8'b0000_0100, 4'b1000, 2'b00, 2'b00, 0, 0, 1, 2'b00, 0, 3'b111);
        W_S21  = cw(8'b0000_0010, 4'b0000, 2'b01, 2'b00, 1, 0, 0, 2'b00, 0, 3'b111);
        W_S6   = cw(8'b1000_0000, 4'b0001, 2'b00, 2'b10, 0, 1, 0, 2'b00, 0, 3'b111);
        W_S27  = cw(8'b0000_1100, 4'b0100, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 3'b111);
        W_S23  = cw(8'b0100_0000, 4'b0010, 2'b00, 2'b00, 0, 0, 0, 2'b11, 0, 3'b111);
        W_S16  = cw(8'h00, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 3'b010);
        W_S13L = cw(8'b0000_0001, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 3'b111);

        Reset_ah = 1'b1; Run = 1'b0; Continue = 1'b0; BEN = 1'b0; IR = 16'h0000;
        @(negedge Clk);
        check_eq("reset_idle", 32'(ctl), 32'(W_IDLE));
        Reset_ah = 1'b0;
        @(negedge Clk);
        check_eq("halted_no_run", 32'(ctl), 32'(W_IDLE));

        fetch("add", 16'h1283, 1'b0);
        cyc("add_s1", W_S1);
        cyc("add_next_s18", W_S18);

        cyc("rst_mid_s33", W_S33);
        #2 Reset_ah = 1'b1;
        #1;
        check_eq("rst_mid_oe_n", 32'(Mem_OE_n), 32'd1);
        check_eq("rst_mid_ctl", 32'(ctl), 32'(W_IDLE));
        @(negedge Clk);
        Reset_ah = 1'b0;
        @(negedge Clk);
        check_eq("rst_mid_halted", 32'(ctl), 32'(W_IDLE));

        fetch("br1", 16'h0A05, 1'b1);
        cyc("br1_s0", W_IDLE);
        cyc("br1_s22", W_S22);
        cyc("br1_s18", W_S18);
        do_reset();

        fetch("br0", 16'h0A05, 1'b0);
        cyc("br0_s0", W_IDLE);
        cyc("br0_s18", W_S18);
        do_reset();

        fetch("jsr", 16'h4800, 1'b0);
        cyc("jsr_s4", W_S4);
        cyc("jsr_s21", W_S21);
        cyc("jsr_s18", W_S18);
        do_reset();

        Continue = 1'b1;
        fetch("str", 16'h7285, 1'b0);
        cyc("str_s7", W_S6);
        cyc("str_s23", W_S23);
        cyc("str_s16a", W_S16);
        cyc("str_s16b", W_S16);
        cyc("str_s18", W_S18);
        Continue = 1'b0;
        do_reset();

        fetch("ldr", 16'h6285, 1'b0);
        cyc("ldr_s6", W_S6);
        cyc("ldr_s25a", W_S33);
        cyc("ldr_s25b", W_S33L);
        cyc("ldr_s27", W_S27);
        cyc("ldr_s18", W_S18);
        do_reset();

        fetch("and", 16'h5283, 1'b0);
        cyc("and_s5", W_S5);
        cyc("and_s18", W_S18);
        do_reset();

        fetch("jmp", 16'hC080, 1'b0);
        cyc("jmp_s12", W_S12);
        cyc("jmp_s18", W_S18);
        do_reset();

        fetch("nop", 16'hF025, 1'b0);
        cyc("nop_s18", W_S18);
        do_reset();

        Continue = 1'b1;
        led_base = led_count;
        fetch("pause", 16'hD0FF, 1'b0);
        cyc("pause_led", W_S13L);
        cyc("pause_held1", W_IDLE);
        cyc("pause_held2", W_IDLE);
        Continue = 1'b0;
        cyc("pause_lo", W_IDLE);
        Continue = 1'b1;
        cyc("pause_hi1", W_IDLE);
        cyc("pause_hi2", W_IDLE);
        Continue = 1'b0;
        cyc("pause_done_s18", W_S18);
        check_eq("pause_led_count", 32'(led_count - led_base), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
